// File: rtl/video_retimer_if.sv
// Bundle between the camera-style pixel source, the retimer and the HDMI encoder side.
// The master drives the capture inputs and observes the timed RGB outputs.
interface video_retimer_if #(
    parameter int X_BITS = 11,
    parameter int Y_BITS = 10
);
    logic              i_vsync;
    logic              i_href;
    logic [23:0]       i_data;
    logic              i_clr_err;
    logic              o_hsync;
    logic              o_vsync;
    logic              o_de;
    logic [7:0]        o_r;
    logic [7:0]        o_g;
    logic [7:0]        o_b;
    logic [X_BITS-1:0] o_x;
    logic [Y_BITS-1:0] o_y;
    logic              o_running;
    logic              o_underflow;
    logic              o_overflow;

    modport master (
        output i_vsync, i_href, i_data, i_clr_err,
        input  o_hsync, o_vsync, o_de, o_r, o_g, o_b, o_x, o_y,
        input  o_running, o_underflow, o_overflow
    );

    modport slave (
        input  i_vsync, i_href, i_data, i_clr_err,
        output o_hsync, o_vsync, o_de, o_r, o_g, o_b, o_x, o_y,
        output o_running, o_underflow, o_overflow
    );
endinterface

// File: rtl/video_retimer.sv
// Line-FIFO display retimer: captures a camera pixel stream and replays it under
// regenerated, programmable video timing as RGB888 with active-area coordinates.
module video_retimer #(
    parameter int H_SYNC     = 12,
    parameter int H_BP       = 278,
    parameter int H_ACT      = 1280,
    parameter int H_FP       = 322,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 11,
    parameter int V_ACT      = 720,
    parameter int V_FP       = 7,
    parameter int X_BITS     = 11,
    parameter int Y_BITS     = 10,
    parameter int IN_FMT     = 0,
    parameter int EXPAND_REP = 0,
    parameter int LB_DEPTH   = 2048,
    parameter int PRELOAD    = 640
) (
    input logic            clk,
    input logic            rst,
    video_retimer_if.slave vif
);
    localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int AW    = $clog2(LB_DEPTH);

    localparam logic [X_BITS-1:0] H_LAST    = X_BITS'(H_TOT - 1);
    localparam logic [X_BITS-1:0] H_SYNC_X  = X_BITS'(H_SYNC);
    localparam logic [X_BITS-1:0] H_ACT_BEG = X_BITS'(H_SYNC + H_BP);
    localparam logic [X_BITS-1:0] H_ACT_END = X_BITS'(H_SYNC + H_BP + H_ACT);
    localparam logic [Y_BITS-1:0] V_LAST    = Y_BITS'(V_TOT - 1);
    localparam logic [Y_BITS-1:0] V_SYNC_Y  = Y_BITS'(V_SYNC);
    localparam logic [Y_BITS-1:0] V_ACT_BEG = Y_BITS'(V_SYNC + V_BP);
    localparam logic [Y_BITS-1:0] V_ACT_END = Y_BITS'(V_SYNC + V_BP + V_ACT);
    localparam logic [AW:0]       FULL_LVL  = (AW + 1)'(LB_DEPTH);
    localparam logic [AW:0]       PRE_LVL   = (AW + 1)'(PRELOAD);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    function automatic logic [7:0] widen5(input logic [4:0] c);
        return (EXPAND_REP != 0) ? {c, c[4:2]} : {c, 3'b000};
    endfunction

    function automatic logic [7:0] widen6(input logic [5:0] c);
        return (EXPAND_REP != 0) ? {c, c[5:4]} : {c, 2'b00};
    endfunction

    // Pixels are stored already expanded, packed as {r, g, b}.
    function automatic logic [23:0] to_rgb(input logic [23:0] d);
        if (IN_FMT == 1) return {d[7:0], d[15:8], d[23:16]};
        return {widen5(d[4:0]), widen6(d[10:5]), widen5(d[15:11])};
    endfunction

    logic [1:0]        state;
    logic [X_BITS-1:0] hc;
    logic [Y_BITS-1:0] vc;
    logic              vsync_d;
    logic              frame_bad;
    logic [23:0]       mem [LB_DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic [AW:0]       fill;
    logic              run, vs_rise, wr_en, rd_req, empty, full;
    logic              pop, push, uf_evt, of_evt, frame_end;
    logic              hsync_p0, vsync_p0, hact_p0, vact_p0, de_p0;
    logic              unused_data;

    assign unused_data = ^vif.i_data;

    assign run       = (state == S_RUN);
    assign vs_rise   = vif.i_vsync & ~vsync_d;
    assign fill      = wptr - rptr;
    assign empty     = (fill == '0);
    assign full      = (fill == FULL_LVL);

    // Stage p0: timing decode straight from the counters
    assign hsync_p0  = (hc < H_SYNC_X);
    assign vsync_p0  = (vc < V_SYNC_Y);
    assign hact_p0   = (hc >= H_ACT_BEG) && (hc < H_ACT_END);
    assign vact_p0   = (vc >= V_ACT_BEG) && (vc < V_ACT_END);
    assign de_p0     = hact_p0 & vact_p0;

    assign rd_req    = run & de_p0;
    assign pop       = rd_req & ~empty;
    assign uf_evt    = rd_req & empty;
    assign wr_en     = vif.i_href & (state != S_IDLE);
    // A same-cycle pop frees the slot, so a write into a full FIFO still lands.
    assign push      = wr_en & (~full | pop);
    assign of_evt    = wr_en & full & ~pop;
    assign frame_end = run && (hc == H_LAST) && (vc == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            hc        <= '0;
            vc        <= '0;
            vsync_d   <= 1'b0;
            frame_bad <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
        end else begin
            vsync_d <= vif.i_vsync;
            case (state)
                S_IDLE:  if (vs_rise) state <= S_ARM;
                S_ARM:   if (fill >= PRE_LVL) state <= S_RUN;
                S_RUN:   if (frame_end && frame_bad) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (run) begin
                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
                end else begin
                    hc <= hc + 1'b1;
                end
            end else begin
                hc <= '0;
                vc <= '0;
            end
            if (frame_end) frame_bad <= 1'b0;
            else if (uf_evt) frame_bad <= 1'b1;
            if (state == S_IDLE) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= to_rgb(vif.i_data);
    end

    // Stage p1: registered outputs, one clock behind the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            vif.o_hsync     <= 1'b0;
            vif.o_vsync     <= 1'b0;
            vif.o_de        <= 1'b0;
            vif.o_r         <= '0;
            vif.o_g         <= '0;
            vif.o_b         <= '0;
            vif.o_x         <= '0;
            vif.o_y         <= '0;
            vif.o_underflow <= 1'b0;
            vif.o_overflow  <= 1'b0;
        end else begin
            vif.o_hsync <= run & hsync_p0;
            vif.o_vsync <= run & vsync_p0;
            vif.o_de    <= rd_req;
            {vif.o_r, vif.o_g, vif.o_b} <= pop ? mem[rptr[AW-1:0]] : 24'h000000;
            vif.o_x     <= rd_req ? hc - H_ACT_BEG : '0;
            vif.o_y     <= rd_req ? vc - V_ACT_BEG : '0;
            vif.o_underflow <= uf_evt | (vif.o_underflow & ~vif.i_clr_err);
            vif.o_overflow  <= of_evt | (vif.o_overflow & ~vif.i_clr_err);
        end
    end

    assign vif.o_running = run;
endmodule

// File: tb/tb_video_retimer.sv
// Bench for video_retimer: two small-timing instances (replicating expansion with a short
// preload, zero-fill expansion with a full-FIFO preload) checked every cycle against a model.
module tb_video_retimer;
    localparam int HS = 2, HB = 2, HA = 8, HF = 2;
    localparam int VS = 1, VB = 1, VA = 4, VF = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int DEPTH = 16;
    localparam int PRE_A = 4, PRE_B = 16;
    localparam int ST_IDLE = 0, ST_ARM = 1, ST_RUN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    video_retimer_if #(.X_BITS(11), .Y_BITS(10)) ifa ();
    video_retimer_if #(.X_BITS(11), .Y_BITS(10)) ifb ();

    video_retimer #(.H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
                    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
                    .X_BITS(11), .Y_BITS(10), .IN_FMT(0), .EXPAND_REP(1),
                    .LB_DEPTH(DEPTH), .PRELOAD(PRE_A))
        dut_a (.clk(clk), .rst(rst), .vif(ifa));

    video_retimer #(.H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
                    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
                    .X_BITS(11), .Y_BITS(10), .IN_FMT(0), .EXPAND_REP(0),
                    .LB_DEPTH(DEPTH), .PRELOAD(PRE_B))
        dut_b (.clk(clk), .rst(rst), .vif(ifb));

    int tests = 0;
    int fails = 0;

    int          m_st[2], m_pos[2], m_cnt[2], m_head[2];
    bit          m_bad[2], m_vp[2];
    logic [23:0] m_fifo[2][DEPTH];
    bit          e_hs[2], e_vs[2], e_de[2], e_uf[2], e_of[2];
    logic [10:0] e_x[2];
    logic [9:0]  e_y[2];
    logic [23:0] e_rgb[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 565 colour expansion by arithmetic; instance 0 replicates MSBs, instance 1 zero-fills.
    function automatic logic [23:0] expand(input int k, input logic [23:0] d);
        int r5, g6, b5, r, g, b;
        r5 = int'(d) % 32;
        g6 = (int'(d) / 32) % 64;
        b5 = (int'(d) / 2048) % 32;
        r = r5 * 8; g = g6 * 4; b = b5 * 8;
        if (k == 0) begin
            r = r + r5 / 4; g = g + g6 / 16; b = b + b5 / 4;
        end
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    // One clock of behaviour: frame position, pixel queue and sticky flags.
    task automatic model_step(input int k, input bit r, input bit vs, input bit hr,
                              input logic [23:0] d, input bit clr);
        int h, v, pre, start_cnt;
        bit run, de, uf, of, fend;
        logic [23:0] pix;
        if (r) begin
            m_st[k] = ST_IDLE; m_pos[k] = 0; m_cnt[k] = 0; m_head[k] = 0;
            m_bad[k] = 0; m_vp[k] = 0;
            e_hs[k] = 0; e_vs[k] = 0; e_de[k] = 0; e_uf[k] = 0; e_of[k] = 0;
            e_x[k] = '0; e_y[k] = '0; e_rgb[k] = '0;
            return;
        end
        pre = (k == 0) ? PRE_A : PRE_B;
        run = (m_st[k] == ST_RUN);
        h = run ? m_pos[k] % HT : 0;
        v = run ? m_pos[k] / HT : 0;
        de = run && h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA;
        uf = 0; of = 0; pix = '0;
        start_cnt = m_cnt[k];
        if (de) begin
            if (m_cnt[k] == 0) uf = 1;
            else begin
                pix = m_fifo[k][m_head[k]];
                m_head[k] = (m_head[k] + 1) % DEPTH;
                m_cnt[k]--;
            end
        end
        if (hr && m_st[k] != ST_IDLE) begin
            if (m_cnt[k] < DEPTH) begin
                m_fifo[k][(m_head[k] + m_cnt[k]) % DEPTH] = expand(k, d);
                m_cnt[k]++;
            end else of = 1;
        end
        e_hs[k] = run && h < HS;
        e_vs[k] = run && v < VS;
        e_de[k] = de;
        e_x[k] = de ? 11'(h - (HS + HB)) : 11'd0;
        e_y[k] = de ? 10'(v - (VS + VB)) : 10'd0;
        e_rgb[k] = pix;
        e_uf[k] = uf || (e_uf[k] && !clr);
        e_of[k] = of || (e_of[k] && !clr);
        fend = run && m_pos[k] == HT * VT - 1;
        case (m_st[k])
            ST_IDLE: begin
                m_cnt[k] = 0; m_head[k] = 0;
                if (vs && !m_vp[k]) m_st[k] = ST_ARM;
            end
            ST_ARM: if (start_cnt >= pre) begin m_st[k] = ST_RUN; m_pos[k] = 0; end
            default: begin
                if (fend) begin
                    if (m_bad[k]) m_st[k] = ST_IDLE;
                    m_bad[k] = 0;
                end else if (uf) m_bad[k] = 1;
                m_pos[k] = fend ? 0 : m_pos[k] + 1;
            end
        endcase
        m_vp[k] = vs;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, rst, ifa.i_vsync, ifa.i_href, ifa.i_data, ifa.i_clr_err);
        model_step(1, rst, ifb.i_vsync, ifb.i_href, ifb.i_data, ifb.i_clr_err);
        #1;
        check("a_timing", {ifa.o_hsync, ifa.o_vsync, ifa.o_de, ifa.o_x, ifa.o_y},
              {e_hs[0], e_vs[0], e_de[0], e_x[0], e_y[0]});
        check("a_pixel", {ifa.o_r, ifa.o_g, ifa.o_b}, e_rgb[0]);
        check("a_flags", {ifa.o_running, ifa.o_underflow, ifa.o_overflow},
              {m_st[0] == ST_RUN, e_uf[0], e_of[0]});
        check("b_timing", {ifb.o_hsync, ifb.o_vsync, ifb.o_de, ifb.o_x, ifb.o_y},
              {e_hs[1], e_vs[1], e_de[1], e_x[1], e_y[1]});
        check("b_pixel", {ifb.o_r, ifb.o_g, ifb.o_b}, e_rgb[1]);
        check("b_flags", {ifb.o_running, ifb.o_underflow, ifb.o_overflow},
              {m_st[1] == ST_RUN, e_uf[1], e_of[1]});
    endtask

    task automatic vsync_pulse();
        ifa.i_vsync = 1'b1; ifb.i_vsync = 1'b1;
        tick(); tick();
        ifa.i_vsync = 1'b0; ifb.i_vsync = 1'b0;
        tick();
    endtask

    task automatic restart();
        ifa.i_href = 1'b0; ifb.i_href = 1'b0;
        ifa.i_clr_err = 1'b0; ifb.i_clr_err = 1'b0;
        rst = 1'b1; tick(); tick();
        rst = 1'b0; tick();
        vsync_pulse();
    endtask

    // Feed a constant 565 word to both instances and check the first displayed pixel.
    task automatic run_color(input logic [23:0] d, input logic [23:0] exp_a,
                             input logic [23:0] exp_b);
        bit seen_a, seen_b;
        seen_a = 0; seen_b = 0;
        restart();
        for (int i = 0; i < 200 && !(seen_a && seen_b); i++) begin
            ifa.i_href = (m_cnt[0] < DEPTH) && ($urandom_range(0, 7) != 0);
            ifb.i_href = (m_cnt[1] < DEPTH) && ($urandom_range(0, 7) != 0);
            ifa.i_data = d; ifb.i_data = d;
            tick();
            if (!seen_a && ifa.o_de) begin
                seen_a = 1;
                check("a_first_px", {ifa.o_r, ifa.o_g, ifa.o_b}, exp_a);
            end
            if (!seen_b && ifb.o_de) begin
                seen_b = 1;
                check("b_first_px", {ifb.o_r, ifb.o_g, ifb.o_b}, exp_b);
            end
        end
        check("a_de_seen", seen_a, 1);
        check("b_de_seen", seen_b, 1);
    endtask

    initial begin
        int hs_cnt, vs_cnt;
        bit was_run, fell;
        hs_cnt = 0; vs_cnt = 0;
        ifa.i_vsync = 0; ifa.i_href = 0; ifa.i_data = '0; ifa.i_clr_err = 0;
        ifb.i_vsync = 0; ifb.i_href = 0; ifb.i_data = '0; ifb.i_clr_err = 0;

        repeat (3) tick();
        check("a_reset_outs", {ifa.o_hsync, ifa.o_vsync, ifa.o_de, ifa.o_r, ifa.o_g, ifa.o_b,
                               ifa.o_x, ifa.o_y, ifa.o_running, ifa.o_underflow,
                               ifa.o_overflow}, 64'd0);
        rst = 1'b0;
        repeat (3) tick();
        vsync_pulse();

        // A: paced random stream; B: continuous burst into a full FIFO, then starved.
        for (int i = 0; i < 300; i++) begin
            ifa.i_href = (m_cnt[0] < DEPTH) && ($urandom_range(0, 7) != 0);
            ifa.i_data = 24'($urandom);
            ifb.i_href = (i < 120);
            ifb.i_data = 24'($urandom);
            ifb.i_clr_err = (i == 30) || (i == 125);
            if (i >= 150 && i < 150 + HT * VT) begin
                if (ifa.o_hsync) hs_cnt++;
                if (ifa.o_vsync) vs_cnt++;
            end
            tick();
            if (i == 30)  check("b_ovf_clr_vs_err", ifb.o_overflow, 1);
            if (i == 125) check("b_ovf_cleared", ifb.o_overflow, 0);
        end
        ifb.i_clr_err = 1'b0;
        check("a_hsync_frame", hs_cnt, HS * VT);
        check("a_vsync_frame", vs_cnt, VS * HT);
        check("a_no_errors", {ifa.o_running, ifa.o_underflow, ifa.o_overflow}, 3'b100);
        check("b_underflow_idle", {ifb.o_running, ifb.o_underflow}, 2'b01);

        // Reset in the middle of a running frame.
        rst = 1'b1;
        tick();
        check("a_midrun_rst", {ifa.o_hsync, ifa.o_vsync, ifa.o_de, ifa.o_r, ifa.o_g, ifa.o_b,
                               ifa.o_x, ifa.o_y, ifa.o_running, ifa.o_underflow,
                               ifa.o_overflow}, 64'd0);
        rst = 1'b0;
        ifa.i_href = 1'b1; ifb.i_href = 1'b1;
        repeat (20) tick();
        check("a_no_vsync_quiet", {ifa.o_running, ifa.o_de, ifa.o_hsync}, 3'b000);
        ifa.i_href = 1'b0; ifb.i_href = 1'b0;

        run_color(24'hA5FFFF, 24'hFFFFFF, 24'hF8FCF8);
        run_color(24'h3C001F, 24'hFF0000, 24'hF80000);

        // Starve A after four pixels: underflow, black pixels, back to IDLE at frame end.
        restart();
        was_run = 0; fell = 0;
        for (int i = 0; i < 400 && !fell; i++) begin
            ifa.i_href = (i < 4); ifb.i_href = (i < 4);
            ifa.i_data = 24'h00FFFF; ifb.i_data = 24'h00FFFF;
            tick();
            if (ifa.o_running) was_run = 1;
            else if (was_run) fell = 1;
        end
        check("a_uf_returned_idle", fell, 1);
        check("a_uf_flag", {ifa.o_running, ifa.o_underflow, ifa.o_overflow}, 3'b010);
        check("b_stays_armed", ifb.o_running, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
